// File: rtl/conv_encoder_punct_if.sv
// Serial bit-stream handshake between the scrambler, the convolutional encoder and the interleaver.
// The encoder is the slave: it receives data bits and returns coded bits.
interface conv_encoder_punct_if;
   logic       frame_start;
   logic [1:0] rate_sel;
   logic       bit_in;
   logic       in_valid;
   logic       in_ready;
   logic       coded_bit;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output frame_start, rate_sel, bit_in, in_valid, out_ready,
      input  in_ready, coded_bit, out_valid
   );

   modport slave (
      input  frame_start, rate_sel, bit_in, in_valid, out_ready,
      output in_ready, coded_bit, out_valid
   );
endinterface

// File: rtl/conv_encoder_punct.sv
// K=7 rate-1/2 convolutional encoder (g0=133o, g1=171o) with 802.11a puncturing to 2/3 or 3/4.
// Accepts one data bit, then serially emits the kept coded bits before accepting the next one.
//
// state  | meaning
// IDLE   | ready for the next data bit; frame_start honoured here
// EMIT_A | presenting the g0 output bit
// EMIT_B | presenting the g1 output bit
module conv_encoder_punct #(
   parameter logic [5:0] RST_STATE = 6'b000000
) (
   input logic                clk,
   input logic                rst_n,
   conv_encoder_punct_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B} state_t;

   localparam logic [1:0] RATE_1_2 = 2'b00;
   localparam logic [1:0] RATE_2_3 = 2'b01;
   localparam logic [1:0] RATE_3_4 = 2'b10;

   state_t     state_q, state_d;
   logic [5:0] sr_q;
   logic [1:0] phase_q;
   logic [1:0] rate_q;
   logic       a_q, b_q, keep_b_q;

   logic       idle;
   logic       accept;
   logic       fs_hit;
   logic [5:0] sr_eff;
   logic [1:0] phase_eff;
   logic [1:0] rate_eff;
   logic [1:0] rate_sel_map;
   logic [1:0] phase_next;
   logic       a_new, b_new;
   logic       keep_a_new, keep_b_new;

   assign idle         = (state_q == IDLE);
   assign bus.in_ready = idle & rst_n;
   assign accept       = bus.in_valid & bus.in_ready;
   assign fs_hit       = idle & bus.frame_start;

   // reserved code 11 falls back to rate 1/2
   assign rate_sel_map = (bus.rate_sel == 2'b11) ? RATE_1_2 : bus.rate_sel;

   // a frame_start coinciding with a data bit encodes that bit from the fresh frame context
   assign sr_eff    = fs_hit ? RST_STATE    : sr_q;
   assign phase_eff = fs_hit ? 2'd0         : phase_q;
   assign rate_eff  = fs_hit ? rate_sel_map : rate_q;

   assign a_new = bus.bit_in ^ sr_eff[1] ^ sr_eff[2] ^ sr_eff[4] ^ sr_eff[5];
   assign b_new = bus.bit_in ^ sr_eff[0] ^ sr_eff[1] ^ sr_eff[2] ^ sr_eff[5];

   always_comb begin
      keep_a_new = 1'b1;
      keep_b_new = 1'b1;
      phase_next = 2'd0;
      case (rate_eff)
         RATE_2_3: begin
            keep_b_new = (phase_eff == 2'd0);
            phase_next = (phase_eff == 2'd1) ? 2'd0 : 2'd1;
         end
         RATE_3_4: begin
            keep_a_new = (phase_eff != 2'd2);
            keep_b_new = (phase_eff != 2'd1);
            phase_next = (phase_eff == 2'd2) ? 2'd0 : phase_eff + 2'd1;
         end
         default: begin
            keep_a_new = 1'b1;
            keep_b_new = 1'b1;
            phase_next = 2'd0;
         end
      endcase
   end

   always_comb begin
      state_d       = state_q;
      bus.out_valid = 1'b0;
      bus.coded_bit = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept)
               state_d = keep_a_new ? EMIT_A : EMIT_B;
         end
         EMIT_A: begin
            bus.out_valid = 1'b1;
            bus.coded_bit = a_q;
            if (bus.out_ready)
               state_d = keep_b_q ? EMIT_B : IDLE;
         end
         EMIT_B: begin
            bus.out_valid = 1'b1;
            bus.coded_bit = b_q;
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sr_q     <= RST_STATE;
         phase_q  <= 2'd0;
         rate_q   <= RATE_1_2;
         a_q      <= 1'b0;
         b_q      <= 1'b0;
         keep_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (fs_hit) begin
            sr_q    <= RST_STATE;
            phase_q <= 2'd0;
            rate_q  <= rate_sel_map;
         end
         if (accept) begin
            sr_q     <= {sr_eff[4:0], bus.bit_in};
            phase_q  <= phase_next;
            a_q      <= a_new;
            b_q      <= b_new;
            keep_b_q <= keep_b_new;
         end
      end
   end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: generator-polynomial reference model with puncture tables,
// a per-transfer compare process, and literal coded sequences for each directed scenario.
module tb_conv_encoder_punct;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   conv_encoder_punct_if bus ();

   conv_encoder_punct dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit exp_q[$];
   bit got_log[$];

   // model: window bit 6 is the current input, bit 6-k the input k steps earlier
   logic [6:0] m_win;
   int         m_phase;
   int         m_rate;
   int         period [3] = '{1, 2, 3};
   bit         keep_a [3][3] = '{'{1, 0, 0}, '{1, 1, 0}, '{1, 1, 0}};
   bit         keep_b [3][3] = '{'{1, 0, 0}, '{1, 0, 0}, '{1, 0, 1}};

   task automatic check(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_win   = 7'd0;
      m_phase = 0;
      m_rate  = 0;
   endtask

   task automatic model_accept(input bit b, input bit fs, input logic [1:0] rs);
      bit ca, cb;
      if (fs) begin
         m_win   = 7'd0;
         m_phase = 0;
         m_rate  = (rs == 2'b11) ? 0 : int'(rs);
      end
      m_win = {b, m_win[6:1]};
      ca = ^(m_win & 7'o133);
      cb = ^(m_win & 7'o171);
      if (keep_a[m_rate][m_phase]) exp_q.push_back(ca);
      if (keep_b[m_rate][m_phase]) exp_q.push_back(cb);
      m_phase = (m_phase + 1) % period[m_rate];
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         got_log.push_back(bus.coded_bit);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got coded_bit %b expected no transfer at %0t",
                     bus.coded_bit, $time);
         end else begin
            check("coded_bit", bus.coded_bit, exp_q.pop_front());
         end
      end
   end

   task automatic send_bit(input bit b, input bit fs, input logic [1:0] rs);
      bit done = 0;
      @(posedge clk) #1;
      bus.bit_in      = b;
      bus.in_valid    = 1'b1;
      bus.frame_start = fs;
      bus.rate_sel    = rs;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            model_accept(b, fs, rs);
            done = 1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready %b expected 1 within 100 cycles", bus.in_ready);
      end
      @(posedge clk) #1;
      bus.in_valid    = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && bus.out_valid === 1'b0) done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_drain: got %0d pending bits expected 0", name, exp_q.size());
      end
      repeat (3) @(negedge clk);
      check({name, "_quiet"}, bus.out_valid, 1'b0);
   endtask

   task automatic check_log(input string name, input logic [31:0] v, input int n);
      checks++;
      if (got_log.size() != n) begin
         errors++;
         $display("FAIL %s_len: got %0d coded bits expected %0d", name, got_log.size(), n);
      end else begin
         for (int i = 0; i < n; i++)
            check($sformatf("%s_bit%0d", name, i), got_log[i], v[n-1-i]);
      end
      got_log.delete();
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.rate_sel    = 2'b00;
      bus.bit_in      = 1'b0;
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b1;
      model_reset();

      repeat (3) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_coded_bit", bus.coded_bit, 1'b0);
      @(posedge clk) #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", bus.in_ready, 1'b1);

      // rate 1/2 impulse response
      send_bit(1, 1, 2'b00);
      for (int i = 0; i < 6; i++) send_bit(0, 0, 2'b00);
      wait_idle("t1");
      check_log("t1", 32'b11_01_11_11_00_10_11, 14);

      // rate 3/4, plus one more bit showing the phase wrapped to 0
      send_bit(1, 1, 2'b10);
      for (int i = 0; i < 6; i++) send_bit(0, 0, 2'b10);
      wait_idle("t2");
      check_log("t2", 32'b1101110011, 10);

      // rate 2/3
      send_bit(1, 1, 2'b01);
      for (int i = 0; i < 3; i++) send_bit(0, 0, 2'b01);
      wait_idle("t3");
      check_log("t3", 32'b110111, 6);

      // stall in EMIT_A; a frame_start pulse during emission must be ignored
      bus.out_ready = 1'b0;
      send_bit(1, 1, 2'b00);
      bus.frame_start = 1'b1;
      bus.rate_sel    = 2'b10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_out_valid", bus.out_valid, 1'b1);
         check("stall_coded_bit", bus.coded_bit, 1'b1);
         check("stall_in_ready", bus.in_ready, 1'b0);
      end
      @(posedge clk) #1;
      bus.frame_start = 1'b0;
      bus.out_ready   = 1'b1;
      send_bit(0, 0, 2'b10);
      wait_idle("t4");
      check_log("t4", 32'b1101, 4);

      // mid-frame frame_start with reserved rate, then rate_sel changes without frame_start
      send_bit(1, 1, 2'b10);
      send_bit(1, 1, 2'b11);
      send_bit(0, 0, 2'b10);
      send_bit(0, 0, 2'b01);
      wait_idle("t5");
      check_log("t5", 32'b11110111, 8);

      // synchronous reset while EMIT_B is pending
      bus.out_ready = 1'b0;
      send_bit(1, 1, 2'b00);
      bus.out_ready = 1'b1;
      @(posedge clk) #1;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_in_ready", bus.in_ready, 1'b0);
      @(posedge clk) #1;
      exp_q.delete();
      model_reset();
      @(negedge clk);
      check("t6_out_valid", bus.out_valid, 1'b0);
      check("t6_coded_bit", bus.coded_bit, 1'b0);
      check_log("t6_pre", 32'b1, 1);
      @(posedge clk) #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      send_bit(1, 0, 2'b10);
      send_bit(0, 0, 2'b10);
      wait_idle("t6");
      check_log("t6", 32'b1101, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
